// File: rtl/bus_pkg.sv
// Shared definitions for the 2-bit serial system bus.
// Lane bit positions, RW encodings and the slave frame states.
package bus_pkg;

    localparam int VALID_BIT = 1;
    localparam int DATA_BIT  = 0;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        TURN,
        RDATA
    } state_e;

endpackage

// File: rtl/slave_regfile.sv
// Slave-local register file: one synchronous write port,
// two combinational read ports, asynchronous clear.
module slave_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/bus_slave_port.sv
// Slave end of the serial bus: deserialises master frames,
// writes the local register file and serialises read data back.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        data_in,
    output logic [1:0]        data_out,
    output logic              busy,
    output logic              wr_pulse,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e state, state_nxt;

    logic              valid;
    logic              sbit;
    logic              rw;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-2:0] wd_sh;
    logic [DATA_W-1:0] rd_sh;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] addr_full;
    logic [DATA_W-1:0] data_full;
    logic [DATA_W-1:0] rdata;
    logic              last_addr;
    logic              last_data;

    logic              we;
    logic              err_nxt;
    logic              wr_nxt;
    logic [1:0]        out_nxt;

    assign valid     = data_in[VALID_BIT];
    assign sbit      = data_in[DATA_BIT];
    assign addr_full = {addr_sh[ADDR_W-2:0], sbit};
    assign data_full = {wd_sh, sbit};
    assign last_addr = (cnt == CNT_W'(ADDR_W - 1));
    assign last_data = (cnt == CNT_W'(DATA_W - 1));
    assign busy      = (state != IDLE);

    // Read address is the fully assembled address, so the word
    // is captured on the same edge that enters TURN.
    slave_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (addr_sh),
        .wdata    (data_full),
        .raddr    (addr_full),
        .rdata    (rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        wr_nxt    = 1'b0;
        out_nxt   = 2'b00;
        we        = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (!valid) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (last_addr) begin
                    state_nxt = (rw == RW_WRITE) ? WDATA : TURN;
                end
            end
            WDATA: begin
                if (!valid) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (last_data) begin
                    state_nxt = IDLE;
                    we        = 1'b1;
                    wr_nxt    = 1'b1;
                end
            end
            TURN: begin
                err_nxt   = valid;
                state_nxt = RDATA;
                out_nxt   = {1'b1, rd_sh[DATA_W-1]};
            end
            RDATA: begin
                err_nxt = valid;
                if (last_data) begin
                    state_nxt = IDLE;
                end else begin
                    out_nxt = {1'b1, rd_sh[DATA_W-1]};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= 2'b00;
            wr_pulse <= 1'b0;
            err      <= 1'b0;
            rw       <= RW_READ;
            addr_sh  <= '0;
            wd_sh    <= '0;
            rd_sh    <= '0;
            cnt      <= '0;
        end else begin
            data_out <= out_nxt;
            wr_pulse <= wr_nxt;
            err      <= err_nxt;
            // Counter restarts on every state change and idles at zero.
            if (state_nxt != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        rw <= sbit;
                    end
                end
                ADDR: begin
                    if (valid) begin
                        addr_sh <= addr_full;
                        if (last_addr) begin
                            rd_sh <= rdata;
                        end
                    end
                end
                WDATA: begin
                    if (valid) begin
                        wd_sh <= data_full[DATA_W-2:0];
                    end
                end
                TURN, RDATA: begin
                    rd_sh <= rd_sh << 1;
                end
                default: ;
            endcase
        end
    end

endmodule
